mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 16, is the word-address width of the shared data RAM port.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 i_req  input  1  fetch requester: read request.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_gnt  output  1  fetch request accepted this cycle.
REQ-007 i_rvalid  output  1  fetch read data valid.
REQ-008 i_rdata  output  32  fetch read data.
REQ-009 d_req  input  1  load/store requester: request.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  load/store byte address.
REQ-012 d_size  input  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-013 d_wdata  input  32  store data, right-aligned.
REQ-014 d_gnt  output  1  load/store request accepted this cycle.
REQ-015 d_rvalid  output  1  load data valid, or store/error completion.
REQ-016 d_rdata  output  32  raw 32-bit word read (no lane extraction).
REQ-017 d_err  output  1  misaligned or illegal-size access; valid with d_rvalid.
REQ-018 m_a  output  ADDR_BITS  RAM word address = winner byte address [ADDR_BITS+1:2].
REQ-019 m_we  output  4  RAM byte write enables.
REQ-020 m_d  output  32  RAM write data.
REQ-021 m_spo  input  32  RAM combinational read data for m_a.

Function
REQ-022 At most one request SHALL be accepted per cycle; i_gnt and d_gnt SHALL be combinational from the req inputs and the priority pointer, and never both be 1.
REQ-023 Arbitration SHALL be round-robin: a 1-bit pointer `last` records the last winner; if both request, the requester that is not `last` wins; a lone requester always wins.
REQ-024 `last` SHALL update on every accepting edge to the accepted requester; it SHALL NOT change in cycles with no acceptance.
REQ-025 An unaccepted requester SHALL hold req and all request fields stable until its gnt; the block SHALL NOT queue requests.
REQ-026 m_a SHALL present the winner's address; with no request m_a SHALL present i_addr word index and m_we SHALL be 0000.
REQ-027 For an accepted read, m_spo SHALL be registered and returned on the winner's rdata with rvalid high exactly one cycle after gnt (latency 1).
REQ-028 rvalid SHALL be a single-cycle pulse per accepted request; back-to-back acceptances SHALL yield back-to-back rvalid pulses.
REQ-029 rdata SHALL hold its last value when rvalid is 0.
REQ-030 Store lane enables, asserted only in the acceptance cycle: byte -> 0001 << addr[1:0]; half -> 0011 << addr[1:0]; word -> 1111.
REQ-031 m_d SHALL replicate the data: byte -> {4{wdata[7:0]}}, half -> {2{wdata[15:0]}}, word -> wdata.
REQ-032 Half with addr[0]=1, word with addr[1:0]!=00, or size=11 is an error: request still accepted, m_we=0000, one cycle later d_rvalid=1 and d_err=1.
REQ-033 A fetch with i_addr[1:0]!=00 SHALL be served as the aligned word (low bits ignored).
REQ-034 Store completion SHALL pulse d_rvalid one cycle after d_gnt with d_err=0; d_rdata SHALL then carry the pre-write word.
REQ-035 d_err SHALL be 0 whenever d_rvalid is 0.

Reset
REQ-036 While rst=1: i_rvalid=0, d_rvalid=0, d_err=0, i_rdata=0, d_rdata=0, `last`=data (so fetch wins the first conflict).
REQ-037 rst asserted during an outstanding read SHALL drop the pending rvalid; no response is delivered after reset release.
REQ-038 Combinational gnt/m_we SHALL still follow the inputs during reset, but no registered state changes until rst=0.

Verification
REQ-039 After reset, i_req=d_req=1 held for 4 cycles -> gnt order i,d,i,d; rvalid pulses in the same order, each 1 cycle after its gnt.
REQ-040 Store byte, d_addr=0x0000_0006, d_wdata=0xAB -> m_a=1, m_we=0100, m_d=0xABABABAB; next cycle d_rvalid=1, d_err=0.
REQ-041 Store half at 0x3, then load word at 0x4 -> first: m_we=0000, d_err=1; second: d_rvalid=1, d_rdata=m_spo of word 1, d_err=0.
REQ-042 Store word 0xDEADBEEF at 0x10, then load 0x10 -> d_rdata=0xDEADBEEF on the cycle after the load's gnt.
REQ-043 Fetch accepted, rst pulsed on the next edge -> i_rvalid stays 0 and `last`=data; after release a conflict grants fetch first.
REQ-044 d_req alone for 3 cycles -> d_gnt each cycle, three consecutive d_rvalid pulses, i_gnt never 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one single-port data RAM
// between an instruction-fetch requester and a load/store requester.
// Grants and RAM drive are combinational. Read data is captured one cycle
// after the grant and returned to the requester that won.
module mem_arbiter #(
   parameter int ADDR_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   // fetch requester
   input  logic                 i_req,
   input  logic [31:0]          i_addr,
   output logic                 i_gnt,
   output logic                 i_rvalid,
   output logic [31:0]          i_rdata,
   // load/store requester
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [31:0]          d_addr,
   input  logic [1:0]           d_size,
   input  logic [31:0]          d_wdata,
   output logic                 d_gnt,
   output logic                 d_rvalid,
   output logic [31:0]          d_rdata,
   output logic                 d_err,
   // shared RAM port
   output logic [ADDR_BITS-1:0] m_a,
   output logic [3:0]           m_we,
   output logic [31:0]          m_d,
   input  logic [31:0]          m_spo
);

   // Identity of the most recently accepted requester.
   typedef enum logic {
      OWNER_FETCH = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   owner_e      last_q, last_d;
   logic        i_rvalid_q, i_rvalid_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic        d_err_q, d_err_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        access_err;
   logic [3:0]  lane_mask;
   logic [31:0] wdata_rep;

   // Only the word-index bits of the byte addresses reach the RAM.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{i_addr, d_addr};

   // Grant: a lone requester wins; on a conflict the one that did not win last.
   always_comb begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (i_req && d_req) begin
         if (last_q == OWNER_DATA) begin
            i_gnt = 1'b1;
         end else begin
            d_gnt = 1'b1;
         end
      end else begin
         i_gnt = i_req;
         d_gnt = d_req;
      end
   end

   // Decode load/store size: lane mask, replicated store data, alignment error.
   always_comb begin
      access_err = 1'b0;
      lane_mask  = 4'b0000;
      wdata_rep  = d_wdata;
      case (d_size)
         2'b00: begin
            lane_mask = 4'b0001 << d_addr[1:0];
            wdata_rep = {4{d_wdata[7:0]}};
         end
         2'b01: begin
            access_err = d_addr[0];
            lane_mask  = 4'b0011 << d_addr[1:0];
            wdata_rep  = {2{d_wdata[15:0]}};
         end
         2'b10: begin
            access_err = |d_addr[1:0];
            lane_mask  = 4'b1111;
         end
         default: begin
            access_err = 1'b1;
         end
      endcase
   end

   // RAM drive: winner's word address; write lanes only for a clean accepted store.
   always_comb begin
      m_a  = d_gnt ? d_addr[ADDR_BITS+1:2] : i_addr[ADDR_BITS+1:2];
      m_d  = wdata_rep;
      m_we = (d_gnt && d_we && !access_err) ? lane_mask : 4'b0000;
   end

   // Next state: track last winner, launch one-cycle responses, capture read data.
   always_comb begin
      last_d     = last_q;
      i_rvalid_d = i_gnt;
      d_rvalid_d = d_gnt;
      d_err_d    = d_gnt && access_err;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      if (d_gnt) begin
         last_d    = OWNER_DATA;
         d_rdata_d = m_spo;
      end else if (i_gnt) begin
         last_d    = OWNER_FETCH;
         i_rdata_d = m_spo;
      end
   end

   // State registers; reset favours fetch on the first conflict and kills pending responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q     <= OWNER_DATA;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         i_rdata_q  <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         last_q     <= last_d;
         i_rvalid_q <= i_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         d_err_q    <= d_err_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign i_rvalid = i_rvalid_q;
   assign i_rdata  = i_rdata_q;
   assign d_rvalid = d_rvalid_q;
   assign d_rdata  = d_rdata_q;
   assign d_err    = d_err_q;

endmodule
